pmem_responder: RTL and testbench
=================================

PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter: LINE_W, 256, cache line width in bits.
REQ-002 Parameter: BEAT_W, 64, burst-side beat width in bits; LINE_W/BEAT_W = 4 beats.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: pmem_address  input  32  line request address from cache.
REQ-006 Port: pmem_read  input  1  line read request.
REQ-007 Port: pmem_write  input  1  line write request.
REQ-008 Port: pmem_wdata  input  LINE_W  line to write.
REQ-009 Port: pmem_rdata  output  LINE_W  assembled read line.
REQ-010 Port: pmem_resp  output  1  one-cycle completion pulse.
REQ-011 Port: burst_address  output  32  line-aligned burst address.
REQ-012 Port: burst_read  output  1  burst read request.
REQ-013 Port: burst_write  output  1  burst write request.
REQ-014 Port: burst_wdata  output  BEAT_W  current write beat.
REQ-015 Port: burst_rdata  input  BEAT_W  read beat data, valid when burst_resp=1.
REQ-016 Port: burst_resp  input  1  one beat transferred this cycle.

Function
REQ-017 FSM states SHALL be IDLE, RD_BURST, WR_BURST, DONE.
REQ-018 In IDLE, pmem_read=1 SHALL latch {pmem_address[31:5],5'b0} and go to RD_BURST; pmem_write=1 SHALL latch the address and pmem_wdata and go to WR_BURST.
REQ-019 pmem_read and pmem_write both high in IDLE SHALL be treated as a write (write priority).
REQ-020 burst_read SHALL be 1 exactly in RD_BURST; burst_write exactly in WR_BURST; burst_address SHALL equal the latched address whenever either is 1, else 0.
REQ-021 A 2-bit beat counter SHALL reset to 0 on entry to a burst state and increment on each cycle with burst_resp=1.
REQ-022 Beat n SHALL map to line bits [64n+63:64n] (beat 0 = least significant).
REQ-023 RD_BURST: on burst_resp, burst_rdata SHALL be written into beat slot n of the read buffer.
REQ-024 WR_BURST: burst_wdata SHALL present latched-line beat n, changing the cycle after each burst_resp.
REQ-025 burst_resp may have gaps of any length between beats; the counter SHALL hold during gaps.
REQ-026 The burst state SHALL transition to DONE on the cycle burst_resp=1 with counter=3.
REQ-027 DONE SHALL assert pmem_resp=1 for exactly one cycle, then return to IDLE.
REQ-028 pmem_rdata SHALL hold the last completed read line, stable from DONE until the next read completes; write bursts SHALL not alter it.
REQ-029 Minimum latency: request seen at cycle 0, burst_resp at cycles 2-5 -> pmem_resp at cycle 6.
REQ-030 Requester deasserts its request in the cycle following pmem_resp; request inputs SHALL be ignored outside IDLE.
REQ-031 burst_resp in IDLE or DONE SHALL be ignored.

Reset
REQ-032 rst=1 SHALL force IDLE, counter=0, pmem_resp=0, burst_read=0, burst_write=0, burst_address=0, burst_wdata=0, pmem_rdata=0 on the next edge.
REQ-033 rst during a burst SHALL abort it with no pmem_resp; partial read beats SHALL be discarded.

Structure
REQ-034 Package pmem_pkg SHALL hold the state enum, LINE_W, BEAT_W and NUM_BEATS=4 constants.
REQ-035 One sub-module, line_beat_buffer (256-bit register with per-beat write enable and 64-bit beat select output), SHALL be instantiated twice: read assembly and write staging.

Verification
REQ-036 Read, back-to-back resp: pmem_address=0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 at cycles 2-5 -> burst_address=0x0000_1220, pmem_resp at cycle 6, pmem_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-037 Write with gaps: pmem_wdata=0xA..A_B..B_C..C_D..D, burst_resp at cycles 2,5,6,9 -> burst_wdata sequence D..D, C..C, B..B, A..A; pmem_resp only at cycle 10.
REQ-038 Simultaneous read+write in IDLE -> burst_write=1, burst_read=0 throughout.
REQ-039 rst asserted after beat 2 of a read -> no pmem_resp, outputs zero next cycle; subsequent read completes correctly with fresh data.
REQ-040 Spurious burst_resp in IDLE, then a write -> counter unaffected, all 4 beats written in order, pmem_rdata unchanged from prior read.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared constants and state encoding for the physical-memory burst responder.
package pmem_pkg;
  localparam int LINE_W    = 256;
  localparam int BEAT_W    = 64;
  localparam int NUM_BEATS = LINE_W / BEAT_W;
  localparam int CNT_W     = $clog2(NUM_BEATS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;
endpackage

// File: rtl/line_beat_buffer.sv
// Line-wide register written one beat slot at a time, with a beat-select read port.
module line_beat_buffer #(
  parameter int LINE_W = pmem_pkg::LINE_W,
  parameter int BEAT_W = pmem_pkg::BEAT_W,
  parameter int NB     = LINE_W / BEAT_W,
  parameter int SW     = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB-1:0]     i_we,
  input  logic [LINE_W-1:0] i_line,
  input  logic [SW-1:0]     i_sel,
  output logic [LINE_W-1:0] o_line,
  output logic [BEAT_W-1:0] o_beat
);
  logic [LINE_W-1:0] r_line;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (i_we[b])
          r_line[b*BEAT_W +: BEAT_W] <= i_line[b*BEAT_W +: BEAT_W];
      end
    end
  end

  assign o_line = r_line;
  assign o_beat = r_line[i_sel*BEAT_W +: BEAT_W];
endmodule

// File: rtl/pmem_responder.sv
// Converts single-line cache requests into four-beat bursts and back.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int LINE_W = pmem_pkg::LINE_W,
  parameter int BEAT_W = pmem_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       burst_address,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);
  localparam int NB = LINE_W / BEAT_W;
  localparam int SW = $clog2(NB);

  state_t            r_state;
  logic [SW-1:0]     r_cnt;
  logic [31:0]       r_baddr;
  logic              r_bread;
  logic              r_bwrite;
  logic              r_resp;
  logic [LINE_W-1:0] r_rdata;

  logic [NB-1:0]     w_rd_we;
  logic [NB-1:0]     w_wr_we;
  logic [LINE_W-1:0] w_rline;
  logic [LINE_W-1:0] w_asm;
  logic [BEAT_W-1:0] w_wbeat;
  logic [LINE_W-1:0] w_unused_wline;
  logic [BEAT_W-1:0] w_unused_rbeat;
  logic              w_unused_addr;
  logic              w_last;

  assign w_unused_addr = ^pmem_address[4:0];
  assign w_last  = burst_resp && (r_cnt == SW'(NB - 1));
  assign w_rd_we = (r_state == RD_BURST && burst_resp) ?
                   (NB'(1) << r_cnt) : '0;
  assign w_wr_we = (r_state == IDLE && pmem_write) ? '1 : '0;

  line_beat_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_rd_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_rd_we),
    .i_line ({NB{burst_rdata}}),
    .i_sel  (r_cnt),
    .o_line (w_rline),
    .o_beat (w_unused_rbeat)
  );

  line_beat_buffer #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_wr_buf (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_wr_we),
    .i_line (pmem_wdata),
    .i_sel  (r_cnt),
    .o_line (w_unused_wline),
    .o_beat (w_wbeat)
  );

  // Final beat bypasses the buffer so the line is visible in DONE.
  always_comb begin
    w_asm = w_rline;
    w_asm[LINE_W-1 -: BEAT_W] = burst_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_baddr  <= '0;
      r_bread  <= 1'b0;
      r_bwrite <= 1'b0;
      r_resp   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (pmem_write) begin
            r_state  <= WR_BURST;
            r_baddr  <= {pmem_address[31:5], 5'b0};
            r_bwrite <= 1'b1;
          end else if (pmem_read) begin
            r_state <= RD_BURST;
            r_baddr <= {pmem_address[31:5], 5'b0};
            r_bread <= 1'b1;
          end
        end
        RD_BURST: begin
          if (burst_resp)
            r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_bread <= 1'b0;
            r_baddr <= '0;
            r_resp  <= 1'b1;
            r_rdata <= w_asm;
          end
        end
        WR_BURST: begin
          if (burst_resp)
            r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state  <= DONE;
            r_bwrite <= 1'b0;
            r_baddr  <= '0;
            r_resp   <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_resp  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pmem_rdata    = r_rdata;
  assign pmem_resp     = r_resp;
  assign burst_address = r_baddr;
  assign burst_read    = r_bread;
  assign burst_write   = r_bwrite;
  assign burst_wdata   = (r_state == WR_BURST) ? w_wbeat : '0;
endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: reads, gapped writes, priority, reset abort.
module tb_pmem_responder;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] B1 = {16{4'h1}};
  localparam logic [63:0] B2 = {16{4'h2}};
  localparam logic [63:0] B3 = {16{4'h3}};
  localparam logic [63:0] B4 = {16{4'h4}};
  localparam logic [63:0] B5 = {16{4'h5}};
  localparam logic [63:0] B6 = {16{4'h6}};
  localparam logic [63:0] B7 = {16{4'h7}};
  localparam logic [63:0] B8 = {16{4'h8}};
  localparam logic [63:0] BA = {16{4'hA}};
  localparam logic [63:0] BB = {16{4'hB}};
  localparam logic [63:0] BC = {16{4'hC}};
  localparam logic [63:0] BD = {16{4'hD}};

  always #5 clk = ~clk;

  pmem_responder dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [63:0]  wexp [1:10];
  logic         wpat [1:10];
  logic [255:0] last_rd;

  initial begin
    rst = 1'b1;
    pmem_address = '0; pmem_read = 0; pmem_write = 0;
    pmem_wdata = '0; burst_rdata = '0; burst_resp = 0;
    tick(); tick();
    chk("rst_resp", 256'(pmem_resp), 256'd0);
    chk("rst_bread", 256'(burst_read), 256'd0);
    chk("rst_bwrite", 256'(burst_write), 256'd0);
    chk("rst_baddr", 256'(burst_address), 256'd0);
    chk("rst_wdata", 256'(burst_wdata), 256'd0);
    chk("rst_rdata", pmem_rdata, 256'd0);
    rst = 1'b0;
    tick();

    // Read with back-to-back beats
    pmem_address = 32'h0000_1234; pmem_read = 1;
    tick();                                     // cycle 1
    pmem_read = 0;
    chk("rd_bread", 256'(burst_read), 256'd1);
    chk("rd_bwrite", 256'(burst_write), 256'd0);
    chk("rd_baddr", 256'(burst_address), 256'h1220);
    chk("rd_resp_c1", 256'(pmem_resp), 256'd0);
    tick();                                     // cycle 2
    burst_resp = 1; burst_rdata = B1; tick();
    burst_rdata = B2; tick();
    chk("rd_resp_c4", 256'(pmem_resp), 256'd0);
    chk("rd_rdata_mid", pmem_rdata, 256'd0);
    burst_rdata = B3; tick();
    burst_rdata = B4; tick();                   // cycle 6
    burst_resp = 0; burst_rdata = '0;
    chk("rd_resp_c6", 256'(pmem_resp), 256'd1);
    chk("rd_rdata", pmem_rdata, {B4, B3, B2, B1});
    chk("rd_bread_done", 256'(burst_read), 256'd0);
    chk("rd_baddr_done", 256'(burst_address), 256'd0);
    tick();                                     // cycle 7
    chk("rd_resp_c7", 256'(pmem_resp), 256'd0);
    chk("rd_rdata_hold", pmem_rdata, {B4, B3, B2, B1});
    tick();

    // Write with gaps: resp at cycles 2,5,6,9
    wexp = '{BD, BD, BC, BC, BC, BB, BA, BA, BA, 64'd0};
    wpat = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 0};
    pmem_address = 32'h8000_00FF; pmem_write = 1;
    pmem_wdata = {BA, BB, BC, BD};
    tick();
    pmem_write = 0; pmem_wdata = '0;
    for (int c = 1; c <= 9; c++) begin
      burst_resp = wpat[c];
      chk($sformatf("wr_bwrite_c%0d", c), 256'(burst_write), 256'd1);
      chk($sformatf("wr_wdata_c%0d", c), 256'(burst_wdata), 256'(wexp[c]));
      chk($sformatf("wr_resp_c%0d", c), 256'(pmem_resp), 256'd0);
      if (c == 1)
        chk("wr_baddr", 256'(burst_address), 256'h8000_00E0);
      tick();
    end
    burst_resp = 0;
    chk("wr_resp_c10", 256'(pmem_resp), 256'd1);
    chk("wr_bwrite_c10", 256'(burst_write), 256'd0);
    chk("wr_wdata_c10", 256'(burst_wdata), 256'd0);
    chk("wr_rdata_kept", pmem_rdata, {B4, B3, B2, B1});
    tick();
    chk("wr_resp_c11", 256'(pmem_resp), 256'd0);
    tick();

    // Simultaneous read+write: write wins
    pmem_address = 32'h0000_0040; pmem_read = 1; pmem_write = 1;
    pmem_wdata = {B8, B7, B6, B5};
    tick();
    pmem_read = 0; pmem_write = 0;
    for (int c = 1; c <= 5; c++) begin
      burst_resp = (c >= 2);
      chk($sformatf("rw_bwrite_c%0d", c), 256'(burst_write), 256'd1);
      chk($sformatf("rw_bread_c%0d", c), 256'(burst_read), 256'd0);
      tick();
    end
    burst_resp = 0;
    chk("rw_resp", 256'(pmem_resp), 256'd1);
    chk("rw_bread_done", 256'(burst_read), 256'd0);
    chk("rw_rdata_kept", pmem_rdata, {B4, B3, B2, B1});
    tick(); tick();

    // Reset after three beats of a read
    pmem_address = 32'h0000_2000; pmem_read = 1;
    tick();
    pmem_read = 0;
    tick();
    burst_resp = 1; burst_rdata = BA; tick();
    burst_rdata = BB; tick();
    burst_rdata = BC; tick();
    burst_resp = 0; rst = 1;
    tick();
    rst = 0;
    chk("ab_resp", 256'(pmem_resp), 256'd0);
    chk("ab_bread", 256'(burst_read), 256'd0);
    chk("ab_baddr", 256'(burst_address), 256'd0);
    chk("ab_rdata", pmem_rdata, 256'd0);
    chk("ab_wdata", 256'(burst_wdata), 256'd0);
    tick();
    chk("ab_resp_after", 256'(pmem_resp), 256'd0);

    // Fresh read after abort
    pmem_address = 32'h0000_ABCD; pmem_read = 1;
    tick();
    pmem_read = 0;
    chk("rd2_baddr", 256'(burst_address), 256'h0000_ABC0);
    burst_resp = 1; burst_rdata = B5; tick();
    burst_rdata = B6; tick();
    burst_rdata = B7; tick();
    burst_rdata = B8; tick();
    burst_resp = 0; burst_rdata = '0;
    last_rd = {B8, B7, B6, B5};
    chk("rd2_resp", 256'(pmem_resp), 256'd1);
    chk("rd2_rdata", pmem_rdata, last_rd);
    tick(); tick();

    // Spurious resp in IDLE, then a back-to-back write
    burst_resp = 1; tick(); tick();
    burst_resp = 0;
    chk("sp_bread", 256'(burst_read), 256'd0);
    chk("sp_resp", 256'(pmem_resp), 256'd0);
    pmem_address = 32'h0000_0100; pmem_write = 1;
    pmem_wdata = {BA, BB, BC, BD};
    tick();
    pmem_write = 0;
    chk("sp_wd0", 256'(burst_wdata), 256'(BD));
    burst_resp = 1; tick();
    chk("sp_wd1", 256'(burst_wdata), 256'(BC));
    tick();
    chk("sp_wd2", 256'(burst_wdata), 256'(BB));
    tick();
    chk("sp_wd3", 256'(burst_wdata), 256'(BA));
    chk("sp_resp_b3", 256'(pmem_resp), 256'd0);
    tick();
    burst_resp = 0;
    chk("sp_resp_done", 256'(pmem_resp), 256'd1);
    chk("sp_rdata_kept", pmem_rdata, last_rd);
    tick();
    chk("sp_resp_end", 256'(pmem_resp), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
